// File: rtl/reg_pkg.sv
// Shared widths and types for the register file and its write-select encoder.
package reg_pkg;

  parameter int DATA_W = 16;
  parameter int NREGS  = 16;
  parameter int IDX_W  = 4;
  parameter int WL_W   = 16;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [WL_W-1:0]   wordline_t;

endpackage

// File: rtl/wl_encode.sv
// Turns the one-hot write wordline into a register index plus valid/multi-hot flags.
module wl_encode
  import reg_pkg::*;
(
  input  logic [WL_W-1:0]  i_wordline,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid,
  output logic             o_multi
);

  logic [IDX_W:0]   w_count;
  logic [IDX_W-1:0] w_idxOr;

  // The index is an OR of set-bit positions; it only means something when o_valid is high.
  always_comb begin
    w_count = '0;
    w_idxOr = '0;
    for (int i = 0; i < WL_W; i++) begin
      if (i_wordline[i]) begin
        w_count = w_count + 1'b1;
        w_idxOr = w_idxOr | IDX_W'(i);
      end
    end
  end

  assign o_idx   = w_idxOr;
  assign o_valid = (w_count == (IDX_W+1)'(1));
  assign o_multi = (w_count >  (IDX_W+1)'(1));

endmodule

// File: rtl/reg_file.sv
// Register file with write-through bypass, a busy-bit scoreboard for hazard
// stalls, and a sticky error flag for malformed write wordlines.
module reg_file #(
  parameter int DATA_W = reg_pkg::DATA_W,
  parameter int NREGS  = reg_pkg::NREGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       Wordline,
  input  logic [DATA_W-1:0] writeData,
  input  logic [3:0]        readIdA,
  input  logic [3:0]        readIdB,
  output logic [DATA_W-1:0] readDataA,
  output logic [DATA_W-1:0] readDataB,
  input  logic              issueValid,
  input  logic [3:0]        issueId,
  output logic              busyA,
  output logic              busyB,
  output logic              stall,
  output logic              wlError
);

  localparam int IDX_W = reg_pkg::IDX_W;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  r_busy;
  logic              r_wlError;

  logic [IDX_W-1:0]  w_wlIdx;
  logic              w_wlValid;
  logic              w_wlMulti;
  logic              w_hitA;
  logic              w_hitB;
  logic [NREGS-1:0]  w_busyNext;

  wl_encode u_wlEnc (
    .i_wordline (Wordline),
    .o_idx      (w_wlIdx),
    .o_valid    (w_wlValid),
    .o_multi    (w_wlMulti)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NREGS; k++) begin
        r_regs[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NREGS; k++) begin
        if (w_wlValid && (w_wlIdx == IDX_W'(k))) begin
          r_regs[k] <= writeData;
        end
      end
    end
  end

  // Write-back clears first, then a same-cycle issue re-sets the bit so the new producer wins.
  always_comb begin
    w_busyNext = r_busy;
    for (int k = 0; k < NREGS; k++) begin
      if (w_wlValid && (w_wlIdx == IDX_W'(k))) begin
        w_busyNext[k] = 1'b0;
      end
      if (issueValid && (issueId == IDX_W'(k))) begin
        w_busyNext[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy    <= '0;
      r_wlError <= 1'b0;
    end else begin
      r_busy <= w_busyNext;
      if (w_wlMulti) begin
        r_wlError <= 1'b1;
      end
    end
  end

  always_comb begin
    w_hitA    = w_wlValid && (w_wlIdx == readIdA);
    w_hitB    = w_wlValid && (w_wlIdx == readIdB);
    readDataA = w_hitA ? writeData : r_regs[readIdA];
    readDataB = w_hitB ? writeData : r_regs[readIdB];
    busyA     = r_busy[readIdA] && !w_hitA;
    busyB     = r_busy[readIdB] && !w_hitB;
    stall     = busyA || busyB;
  end

  assign wlError = r_wlError;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus random traffic
// compared against an array-based reference model.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] Wordline;
  logic [15:0] writeData;
  logic [3:0]  readIdA;
  logic [3:0]  readIdB;
  logic [15:0] readDataA;
  logic [15:0] readDataB;
  logic        issueValid;
  logic [3:0]  issueId;
  logic        busyA;
  logic        busyB;
  logic        stall;
  logic        wlError;

  int total = 0;
  int bad   = 0;

  logic [15:0] mdlReg  [16];
  logic        mdlBusy [16];
  logic        mdlErr;

  reg_file dut (
    .clk        (clk),
    .reset      (reset),
    .Wordline   (Wordline),
    .writeData  (writeData),
    .readIdA    (readIdA),
    .readIdB    (readIdB),
    .readDataA  (readDataA),
    .readDataB  (readDataB),
    .issueValid (issueValid),
    .issueId    (issueId),
    .busyA      (busyA),
    .busyB      (busyB),
    .stall      (stall),
    .wlError    (wlError)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Index of the single set bit, or -1 when the wordline is not one-hot.
  function automatic int oneHotIdx(input logic [15:0] wl);
    if ($countones(wl) != 1) return -1;
    for (int i = 0; i < 16; i++) if (wl[i]) return i;
    return -1;
  endfunction

  task automatic drive(input logic [15:0] wl, input logic [15:0] wd,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic iv, input logic [3:0] id, input logic rst);
    Wordline   = wl;
    writeData  = wd;
    readIdA    = ra;
    readIdB    = rb;
    issueValid = iv;
    issueId    = id;
    reset      = rst;
    #2;
  endtask

  task automatic checkOutput(input string tag);
    int k;
    logic [15:0] expA, expB;
    logic eBA, eBB;
    k    = oneHotIdx(Wordline);
    expA = (k == int'(readIdA)) ? writeData : mdlReg[readIdA];
    expB = (k == int'(readIdB)) ? writeData : mdlReg[readIdB];
    eBA  = mdlBusy[readIdA] && (k != int'(readIdA));
    eBB  = mdlBusy[readIdB] && (k != int'(readIdB));
    chk({tag, ":readDataA"}, 32'(readDataA), 32'(expA));
    chk({tag, ":readDataB"}, 32'(readDataB), 32'(expB));
    chk({tag, ":busyA"},     32'(busyA),     32'(eBA));
    chk({tag, ":busyB"},     32'(busyB),     32'(eBB));
    chk({tag, ":stall"},     32'(stall),     32'(eBA || eBB));
    chk({tag, ":wlError"},   32'(wlError),   32'(mdlErr));
  endtask

  task automatic tick();
    int k;
    @(posedge clk);
    k = oneHotIdx(Wordline);
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        mdlReg[i]  = '0;
        mdlBusy[i] = 1'b0;
      end
      mdlErr = 1'b0;
    end else begin
      if ($countones(Wordline) > 1) mdlErr = 1'b1;
      if (k >= 0) begin
        mdlReg[k]  = writeData;
        mdlBusy[k] = 1'b0;
      end
      if (issueValid) mdlBusy[issueId] = 1'b1;
    end
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] wl, input logic [15:0] wd,
                               input logic [3:0] ra, input logic [3:0] rb,
                               input logic iv, input logic [3:0] id,
                               input logic rst, input string tag);
    drive(wl, wd, ra, rb, iv, id, rst);
    checkOutput(tag);
    tick();
  endtask

  initial begin
    logic [15:0] wl;
    int mode;
    for (int i = 0; i < 16; i++) begin
      mdlReg[i]  = 'x;
      mdlBusy[i] = 1'b0;
    end
    mdlErr = 1'b0;

    drive(16'h0, 16'h0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1);
    tick();
    tick();

    for (int i = 0; i < 16; i++) begin
      drive(16'h0, 16'h0, 4'(i), 4'(15 - i), 1'b0, 4'd0, 1'b0);
      chk($sformatf("rst_readA_%0d", i), 32'(readDataA), 32'h0);
      chk($sformatf("rst_readB_%0d", i), 32'(readDataB), 32'h0);
      chk($sformatf("rst_stall_%0d", i), 32'(stall), 32'h0);
      chk($sformatf("rst_wlErr_%0d", i), 32'(wlError), 32'h0);
    end

    drive(16'h0008, 16'hBEEF, 4'd3, 4'd2, 1'b0, 4'd0, 1'b0);
    chk("bypass_A_r3", 32'(readDataA), 32'hBEEF);
    chk("nobypass_B_r2", 32'(readDataB), 32'h0);
    tick();
    drive(16'h0, 16'h0, 4'd3, 4'd3, 1'b0, 4'd0, 1'b0);
    chk("r3_after_write", 32'(readDataA), 32'hBEEF);
    chk("r3_portB_same_idx", 32'(readDataB), 32'hBEEF);

    applyStimulus(16'h0, 16'h0, 4'd0, 4'd0, 1'b1, 4'd5, 1'b0, "issue5");
    drive(16'h0, 16'h0, 4'd0, 4'd5, 1'b0, 4'd0, 1'b0);
    chk("busyB_r5", 32'(busyB), 32'h1);
    chk("stall_r5", 32'(stall), 32'h1);
    chk("busyA_r0_clear", 32'(busyA), 32'h0);
    drive(16'h0020, 16'h5555, 4'd0, 4'd5, 1'b0, 4'd0, 1'b0);
    chk("busyB_r5_bypass", 32'(busyB), 32'h0);
    chk("stall_r5_bypass", 32'(stall), 32'h0);
    chk("readB_r5_bypass", 32'(readDataB), 32'h5555);
    tick();
    drive(16'h0, 16'h0, 4'd0, 4'd5, 1'b0, 4'd0, 1'b0);
    chk("busyB_r5_cleared", 32'(busyB), 32'h0);

    applyStimulus(16'h0080, 16'hA7A7, 4'd0, 4'd0, 1'b1, 4'd7, 1'b0, "issue_write7");
    drive(16'h0, 16'h0, 4'd7, 4'd0, 1'b0, 4'd0, 1'b0);
    chk("busyA_r7_set_wins", 32'(busyA), 32'h1);
    chk("r7_new_data", 32'(readDataA), 32'hA7A7);

    applyStimulus(16'h0001, 16'h0C0C, 4'd0, 4'd4, 1'b0, 4'd0, 1'b0, "w_r0");
    applyStimulus(16'h0010, 16'h4040, 4'd0, 4'd4, 1'b0, 4'd0, 1'b0, "w_r4");
    drive(16'h0011, 16'h1234, 4'd0, 4'd4, 1'b0, 4'd0, 1'b0);
    chk("multi_noBypassA", 32'(readDataA), 32'h0C0C);
    chk("multi_noBypassB", 32'(readDataB), 32'h4040);
    tick();
    drive(16'h0, 16'h0, 4'd0, 4'd4, 1'b0, 4'd0, 1'b0);
    chk("multi_r0_kept", 32'(readDataA), 32'h0C0C);
    chk("multi_r4_kept", 32'(readDataB), 32'h4040);
    chk("wlError_set", 32'(wlError), 32'h1);
    applyStimulus(16'h0004, 16'h2222, 4'd2, 4'd7, 1'b0, 4'd0, 1'b0, "after_multi");
    drive(16'h0, 16'h0, 4'd7, 4'd7, 1'b0, 4'd0, 1'b0);
    chk("wlError_sticky", 32'(wlError), 32'h1);
    chk("multi_keeps_busy7", 32'(busyA), 32'h1);

    drive(16'h0002, 16'hFFFF, 4'd1, 4'd7, 1'b1, 4'd9, 1'b1);
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(16'h0, 16'h0, 4'(i), 4'(i), 1'b0, 4'd0, 1'b0);
      chk($sformatf("rst2_read_%0d", i), 32'(readDataA), 32'h0);
      chk($sformatf("rst2_busy_%0d", i), 32'(busyA), 32'h0);
    end
    chk("rst2_wlError", 32'(wlError), 32'h0);

    for (int n = 0; n < 400; n++) begin
      mode = $urandom_range(0, 9);
      if (mode < 2)      wl = 16'h0;
      else if (mode < 8) wl = 16'h1 << $urandom_range(0, 15);
      else               wl = 16'($urandom) | (16'h1 << $urandom_range(0, 7)) | (16'h100 << $urandom_range(0, 7));
      applyStimulus(wl, 16'($urandom), 4'($urandom), 4'($urandom),
                    1'($urandom), 4'($urandom), ($urandom_range(0, 49) == 0),
                    $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
